// File: rtl/mem_port_scheduler_if.sv
// Core-side request/response bundle plus the shared memory port of mem_port_scheduler.
// The per-core lock vector exists only when MEM_PORT_SCHED_LOCK_EN is defined.
interface mem_port_scheduler_if #(
    parameter int WIDTH    = 32,
    parameter int CORE_NUM = 4
);
    logic [CORE_NUM-1:0]       request;
    logic [CORE_NUM-1:0]       wren_core;
    logic [CORE_NUM*WIDTH-1:0] address_in;
    logic [CORE_NUM*WIDTH-1:0] data_in;
`ifdef MEM_PORT_SCHED_LOCK_EN
    logic [CORE_NUM-1:0]       lock;
`endif
    logic [WIDTH-1:0]          data_read;
    logic [CORE_NUM*WIDTH-1:0] data_out;
    logic [CORE_NUM-1:0]       response;
    logic [WIDTH-1:0]          address;
    logic [WIDTH-1:0]          data_write;
    logic                      wren;
    logic                      busy;

`ifdef MEM_PORT_SCHED_LOCK_EN
    modport slave (
        input  request, wren_core, address_in, data_in, lock, data_read,
        output data_out, response, address, data_write, wren, busy
    );
    modport master (
        output request, wren_core, address_in, data_in, lock, data_read,
        input  data_out, response, address, data_write, wren, busy
    );
`else
    modport slave (
        input  request, wren_core, address_in, data_in, data_read,
        output data_out, response, address, data_write, wren, busy
    );
    modport master (
        output request, wren_core, address_in, data_in, data_read,
        input  data_out, response, address, data_write, wren, busy
    );
`endif
endinterface

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler serialising CORE_NUM cores onto one memory port, one access at a time.
// Define MEM_PORT_SCHED_LOCK_EN to let a core keep the port for back-to-back atomic accesses.
module mem_port_scheduler #(
    parameter int WIDTH      = 32,
    parameter int CORE_NUM   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_scheduler_if.slave io_bus
);
    localparam int IDX_W = $clog2(CORE_NUM);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_grant, w_grant_nxt;
    logic [IDX_W-1:0]          r_rr_ptr, w_rr_ptr_nxt;
    logic [CORE_NUM-1:0]       r_cooldown, w_cooldown_nxt;
    logic [CNT_W-1:0]          r_lat_cnt, w_lat_cnt_nxt;
    logic                      r_is_write, w_is_write_nxt;
    logic [WIDTH-1:0]          r_address, w_address_nxt;
    logic [WIDTH-1:0]          r_data_write, w_data_write_nxt;
    logic                      r_wren, w_wren_nxt;
    logic                      r_busy;
    logic [CORE_NUM-1:0]       r_response, w_response_nxt;
    logic [CORE_NUM*WIDTH-1:0] r_data_out, w_data_out_nxt;
`ifdef MEM_PORT_SCHED_LOCK_EN
    logic                      r_locked, w_locked_nxt;
`endif

    logic [CORE_NUM-1:0]       w_eligible;
    logic [IDX_W:0]            w_sum;
    logic [IDX_W-1:0]          w_pos;
    logic [IDX_W-1:0]          w_pick;
    logic                      w_pick_valid;

    // Scan downward so the last hit written is the first eligible core at or after rr_ptr.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
        w_eligible   = io_bus.request & ~r_cooldown;
        w_sum        = '0;
        w_pos        = '0;
        w_pick       = r_rr_ptr;
        w_pick_valid = 1'b0;
        for (int i = CORE_NUM - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= (IDX_W + 1)'(CORE_NUM)) w_sum = w_sum - (IDX_W + 1)'(CORE_NUM);
            w_pos = w_sum[IDX_W-1:0];
            if (w_eligible[w_pos]) begin
                w_pick       = w_pos;
                w_pick_valid = 1'b1;
            end
        end
`ifdef MEM_PORT_SCHED_LOCK_EN
        if (r_locked && io_bus.request[r_grant]) begin
            w_pick       = r_grant;
            w_pick_valid = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = r_is_write ? RESP : WAIT;
            WAIT:    if (r_lat_cnt == '0) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt      = r_grant;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_cooldown_nxt   = r_cooldown;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_is_write_nxt   = r_is_write;
        w_address_nxt    = r_address;
        w_data_write_nxt = r_data_write;
        w_wren_nxt       = 1'b0;
        w_response_nxt   = '0;
        w_data_out_nxt   = r_data_out;
`ifdef MEM_PORT_SCHED_LOCK_EN
        w_locked_nxt     = r_locked;
`endif
        case (r_state)
            IDLE: begin
                w_cooldown_nxt = '0;
`ifdef MEM_PORT_SCHED_LOCK_EN
                w_locked_nxt   = 1'b0;
`endif
                if (w_pick_valid) begin
                    w_grant_nxt      = w_pick;
                    w_address_nxt    = io_bus.address_in[w_pick*WIDTH +: WIDTH];
                    w_data_write_nxt = io_bus.data_in[w_pick*WIDTH +: WIDTH];
                    w_is_write_nxt   = io_bus.wren_core[w_pick];
                    w_wren_nxt       = io_bus.wren_core[w_pick];
                end
            end
            ISSUE: begin
                if (r_is_write) w_response_nxt[r_grant] = 1'b1;
                else            w_lat_cnt_nxt = CNT_W'(RD_LATENCY - 1);
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_data_out_nxt[r_grant*WIDTH +: WIDTH] = io_bus.data_read;
                    w_response_nxt[r_grant]                = 1'b1;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                end
            end
            RESP: begin
                w_rr_ptr_nxt            = (r_grant == IDX_W'(CORE_NUM - 1)) ? '0 : r_grant + 1'b1;
                w_cooldown_nxt          = '0;
                w_cooldown_nxt[r_grant] = 1'b1;
`ifdef MEM_PORT_SCHED_LOCK_EN
                // A locked core keeps its turn: no pointer advance and no cooldown.
                if (io_bus.lock[r_grant]) begin
                    w_locked_nxt   = 1'b1;
                    w_rr_ptr_nxt   = r_rr_ptr;
                    w_cooldown_nxt = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_cooldown   <= '0;
            r_lat_cnt    <= '0;
            r_is_write   <= 1'b0;
            r_address    <= '0;
            r_data_write <= '0;
            r_wren       <= 1'b0;
            r_busy       <= 1'b0;
            r_response   <= '0;
            r_data_out   <= '0;
`ifdef MEM_PORT_SCHED_LOCK_EN
            r_locked     <= 1'b0;
`endif
        end else begin
            r_grant      <= w_grant_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_cooldown   <= w_cooldown_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_is_write   <= w_is_write_nxt;
            r_address    <= w_address_nxt;
            r_data_write <= w_data_write_nxt;
            r_wren       <= w_wren_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_response   <= w_response_nxt;
            r_data_out   <= w_data_out_nxt;
`ifdef MEM_PORT_SCHED_LOCK_EN
            r_locked     <= w_locked_nxt;
`endif
        end
    end

    assign io_bus.address    = r_address;
    assign io_bus.data_write = r_data_write;
    assign io_bus.wren       = r_wren;
    assign io_bus.busy       = r_busy;
    assign io_bus.response   = r_response;
    assign io_bus.data_out   = r_data_out;
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed scenarios followed by randomized core traffic checked against a transaction-level model
// of round-robin service, memory contents and per-core read data.
module tb_mem_port_scheduler;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_scheduler_if #(.WIDTH(WIDTH), .CORE_NUM(N)) bus ();

    mem_port_scheduler #(.WIDTH(WIDTH), .CORE_NUM(N), .RD_LATENCY(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    function automatic logic [31:0] init_word(input logic [5:0] a);
        return (a == 6'h20) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(a));
    endfunction

    // Memory device: write on wren, read data appears LAT cycles after the address.
    logic [31:0] ram     [64];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(6'(i));
        end else if (bus.wren) begin
            ram[bus.address[5:0]] <= bus.data_write;
        end
        rd_pipe[0] <= ram[bus.address[5:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.data_read = rd_pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic req, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        bus.request[i]                   = req;
        bus.wren_core[i]                 = wr;
        bus.address_in[i*WIDTH +: WIDTH] = a;
        bus.data_in[i*WIDTH +: WIDTH]    = d;
    endtask

    task automatic clear_cores();
        for (int i = 0; i < N; i++) set_core(i, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic        pend;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        int          gap;
        int          wait_c;
    } agent_t;

    agent_t         ag [N];
    logic [31:0]    exp_mem [64];
    logic [127:0]   exp_dout;
    int             exp_ptr;
    int             slot;
    int             resp_slot;
    int             cur_g;
    logic           cur_wr;
    logic [31:0]    cur_rdata;
    logic           in_flight;
    logic           prev_busy;
    int             n_resp;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic monitor_slot();
        logic [N-1:0] exp_resp;
        int           g;
        logic         issue;
        exp_resp = '0;
        issue    = bus.busy && !prev_busy;
        if (issue) begin
            g = rr_pick(bus.request, exp_ptr);
            check("rand_grant_exists", (g >= 0), 1'b1);
            if (g >= 0) begin
                check("rand_issue_addr", bus.address, 32'(ag[g].addr));
                check("rand_issue_wren", bus.wren, ag[g].wr);
                if (ag[g].wr) begin
                    check("rand_issue_data", bus.data_write, ag[g].data);
                    exp_mem[ag[g].addr] = ag[g].data;
                end
                cur_g     = g;
                cur_wr    = ag[g].wr;
                cur_rdata = exp_mem[ag[g].addr];
                resp_slot = slot + (ag[g].wr ? 1 : 1 + LAT);
                exp_ptr   = (g + 1) % N;
                in_flight = 1'b1;
            end
        end else begin
            check("rand_wren_quiet", bus.wren, 1'b0);
        end
        if (in_flight && slot == resp_slot) begin
            exp_resp[cur_g] = 1'b1;
            if (!cur_wr) exp_dout[cur_g*WIDTH +: WIDTH] = cur_rdata;
            check("rand_data_out", bus.data_out, exp_dout);
            in_flight = 1'b0;
        end
        check("rand_response", bus.response, exp_resp);
        prev_busy = bus.busy;
    endtask

    task automatic drive_agents();
        for (int i = 0; i < N; i++) begin
            if (ag[i].pend) begin
                if (bus.response[i]) begin
                    check("rand_wait_bound", (ag[i].wait_c <= 40), 1'b1);
                    ag[i].pend = 1'b0;
                    ag[i].gap  = $urandom_range(2, 5);
                end else begin
                    ag[i].wait_c++;
                end
            end else begin
                if (ag[i].gap > 0) ag[i].gap--;
                if (ag[i].gap == 0) begin
                    ag[i].pend   = 1'b1;
                    ag[i].wr     = 1'($urandom_range(0, 1));
                    ag[i].addr   = 6'($urandom_range(0, 15));
                    ag[i].data   = $urandom;
                    ag[i].wait_c = 0;
                end
            end
            set_core(i, ag[i].pend, ag[i].wr, 32'(ag[i].addr), ag[i].data);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_cores();
`ifdef MEM_PORT_SCHED_LOCK_EN
        bus.lock = '0;
`endif
        tick(); tick(); tick();
        check("reset_ctrl", {bus.busy, bus.wren, bus.response, bus.address, bus.data_write}, '0);
        check("reset_data_out", bus.data_out, '0);
        reset = 1'b0;
        tick();

        // Single write from core 2
        set_core(2, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick();
        check("wr_issue", {bus.busy, bus.wren, bus.address, bus.data_write}, {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF});
        check("wr_issue_noresp", bus.response, 4'b0000);
        tick();
        check("wr_resp", {bus.response, bus.wren}, {4'b0100, 1'b0});
        set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("wr_idle", {bus.busy, bus.response}, '0);

        // Single read from core 1, data returns LAT cycles after the address
        set_core(1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        check("rd_issue", {bus.busy, bus.wren, bus.address}, {1'b1, 1'b0, 32'h20});
        tick();
        check("rd_wait1", {bus.wren, bus.response, bus.address}, {1'b0, 4'b0000, 32'h20});
        tick();
        check("rd_wait2", {bus.wren, bus.response}, '0);
        tick();
        check("rd_resp", bus.response, 4'b0010);
        check("rd_data_out", bus.data_out, 128'(32'h1234) << 32);
        set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rd_idle", {bus.busy, bus.response}, '0);

        // Reset while a read is waiting on memory
        set_core(1, 1'b1, 1'b0, 32'h21, 32'h0);
        tick();
        tick();
        check("rst_mid_in_wait", bus.busy, 1'b1);
        reset = 1'b1;
        set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rst_mid_ctrl", {bus.busy, bus.wren, bus.response, bus.address, bus.data_write}, '0);
        check("rst_mid_data_out", bus.data_out, '0);
        reset = 1'b0;
        tick();
        check("rst_mid_no_resp", {bus.busy, bus.response}, '0);

        // All cores request continuously: order 0,1,2,3,0 proves the pointer restarted at 0
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, 32'h30 + 32'(i), 32'h100 + 32'(i));
        n_resp = 0;
        for (int c = 0; c < 40 && n_resp < 5; c++) begin
            tick();
            if (bus.wren) check("rr_issue_addr", bus.address, 32'h30 + 32'(n_resp % N));
            if (bus.response != '0) begin
                check("rr_order", bus.response, 4'b0001 << (n_resp % N));
                n_resp++;
            end
        end
        check("rr_count", n_resp, 5);
        clear_cores();
        repeat (6) tick();

        // Core 3 alone holds request one cycle past its response: must not be re-served
        set_core(3, 1'b1, 1'b1, 32'h40, 32'h33);
        tick();
        check("cd_issue", {bus.wren, bus.address}, {1'b1, 32'h40});
        tick();
        check("cd_resp", bus.response, 4'b1000);
        tick();
        tick();
        check("cd_no_regrant", bus.busy, 1'b0);
        set_core(3, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("cd_quiet", {bus.busy, bus.response}, '0);

        // Core 3 lingers while core 0 requests: core 0 goes next, core 3 only once
        set_core(3, 1'b1, 1'b1, 32'h44, 32'h44);
        tick();
        check("cd2_issue3", {bus.wren, bus.address}, {1'b1, 32'h44});
        tick();
        check("cd2_resp3", bus.response, 4'b1000);
        set_core(0, 1'b1, 1'b1, 32'h50, 32'h55);
        tick();
        tick();
        check("cd2_issue0", {bus.busy, bus.wren, bus.address}, {1'b1, 1'b1, 32'h50});
        set_core(3, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("cd2_resp0", bus.response, 4'b0001);
        set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("cd2_quiet", {bus.busy, bus.response}, '0);

`ifdef MEM_PORT_SCHED_LOCK_EN
        // Locked read-modify-write on core 1 while core 2 waits
        bus.lock = 4'b0010;
        set_core(1, 1'b1, 1'b0, 32'h20, 32'h0);
        set_core(2, 1'b1, 1'b1, 32'h60, 32'h77);
        tick();
        check("lk_rd_issue", {bus.wren, bus.address}, {1'b0, 32'h20});
        tick(); tick(); tick();
        check("lk_rd_resp", bus.response, 4'b0010);
        check("lk_rd_data", bus.data_out, 128'(32'h1234) << 32);
        set_core(1, 1'b1, 1'b1, 32'h20, 32'hABCD);
        tick();
        tick();
        check("lk_wr_issue", {bus.busy, bus.wren, bus.address, bus.data_write}, {1'b1, 1'b1, 32'h20, 32'hABCD});
        tick();
        check("lk_wr_resp", bus.response, 4'b0010);
        set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.lock = '0;
        tick();
        tick();
        check("lk_next_core2", {bus.wren, bus.address}, {1'b1, 32'h60});
        tick();
        check("lk_resp2", bus.response, 4'b0100);
        set_core(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
`endif

        // Randomized traffic against the transaction model
        reset = 1'b1;
        clear_cores();
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(6'(i));
        for (int i = 0; i < N; i++) begin
            ag[i].pend   = 1'b0;
            ag[i].wr     = 1'b0;
            ag[i].addr   = '0;
            ag[i].data   = '0;
            ag[i].gap    = $urandom_range(1, 3);
            ag[i].wait_c = 0;
        end
        exp_dout  = '0;
        exp_ptr   = 0;
        slot      = 0;
        resp_slot = -1;
        cur_g     = 0;
        cur_wr    = 1'b0;
        cur_rdata = '0;
        in_flight = 1'b0;
        prev_busy = 1'b0;
        for (int c = 0; c < 800; c++) begin
            tick();
            slot++;
            monitor_slot();
            drive_agents();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Round-robin scheduler that shares the single videocard data-memory port between CORE_NUM shader cores.
- Serialises one access at a time: write or read.
- Drives the external address, data and wren lines.
- Captures read data after a fixed memory latency and returns a one-cycle response pulse to the granted core.

Parameters:
- WIDTH, 32, data/address width.
- CORE_NUM, 4, number of requesting cores (2..8).
- RD_LATENCY, 1, memory read latency in cycles from address valid to data_read valid (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- request  in  CORE_NUM  per-core access request, held until response.
- wren_core  in  CORE_NUM  per-core write enable, qualified by request.
- address_in  in  CORE_NUM*WIDTH  flattened core addresses; core i at [i*WIDTH +: WIDTH].
- data_in  in  CORE_NUM*WIDTH  flattened core write data.
- data_read  in  WIDTH  memory read data.
- data_out  out  CORE_NUM*WIDTH  flattened per-core read data.
- response  out  CORE_NUM  one-cycle completion pulse per core.
- address  out  WIDTH  memory address.
- data_write  out  WIDTH  memory write data.
- wren  out  1  memory write strobe.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking: all outputs registered; clk only; reset synchronous, active-high, and wins over every other event.
- Reset values:
  - All outputs 0.
  - State = IDLE; rr_ptr = 0; cooldown mask = 0; lat_cnt = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - eligible = request & ~cooldown.
  - If eligible != 0: pick the first set bit searching upward from rr_ptr with wrap-around (rr_ptr itself first).
  - On that pick: latch grant g; register address = address_in[g], data_write = data_in[g], wren = wren_core[g]; go to ISSUE.
  - Clear cooldown every IDLE cycle.
- ISSUE (1 cycle):
  - address/data_write valid; wren high only for writes, for this single cycle.
  - Write: go to RESP.
  - Read: lat_cnt = RD_LATENCY-1; go to WAIT.
- WAIT:
  - Address held; wren = 0.
  - When lat_cnt == 0, capture data_read into data_out[g] and go to RESP; else decrement.
- RESP (1 cycle):
  - response[g] = 1.
  - rr_ptr = (g+1) mod CORE_NUM; cooldown = one-hot g; go to IDLE.
- Cooldown: masks the just-served core for exactly the following IDLE cycle, so a request still high one cycle after response is not re-served.
- Latency (request sampled in IDLE at cycle t):
  - Write: wren at t+1, response at t+2.
  - Read: address from t+1, data_read sampled at t+RD_LATENCY+1, response and data_out valid at t+RD_LATENCY+2.
- data_out[i]: updated only on read completion for core i; holds its value otherwise, including across writes.
- Request rules:
  - Request/wren_core/address/data changes while not in IDLE are ignored; values are latched at grant.
  - A request withdrawn before grant is simply never served.
- Simultaneous requests: resolved only in IDLE by round-robin; no core is starved; worst-case wait is (CORE_NUM-1) services.
- Reset mid-access: access abandoned, no response issued, wren dropped in the same clock edge.

Optional Feature:
- Macro: MEM_PORT_SCHED_LOCK_EN.
- With the macro:
  - Adds input lock [CORE_NUM].
  - If lock[g] is high in RESP, the next IDLE cycle skips round-robin and cooldown and grants g again if request[g] is high, giving atomic read-modify-write sequences.
  - rr_ptr is not advanced while locked.
  - Lock ignored for cores other than g.
- Without the macro: no lock port; pure round-robin as above.

Test Plan:
- Single write: reset, then core2 request=1, wren_core=1, addr 0x10, data 0xDEADBEEF → wren=1 with addr 0x10/data 0xDEADBEEF one cycle later; response=0100 the following cycle; busy drops after.
- Single read, RD_LATENCY=2: core1 reads addr 0x20, memory returns 0x1234 two cycles after address → response=0010 and data_out[1]=0x1234 at t+4; data_out[0,2,3] unchanged.
- All four cores request continuously from reset → grant order 0,1,2,3,0; each core exactly one response per four services.
- Core3 holds request one cycle past its response while core0 also requests → core0 served next; core3 not double-served.
- Reset asserted during WAIT of a read → next cycle all outputs 0, no response pulse, state IDLE, rr_ptr=0.
- With MEM_PORT_SCHED_LOCK_EN: core1 read then write with lock=1 while core2 requests → core1 read and write back-to-back, then core2.
